tl_source_shrink_ctrl: RTL and testbench

Source-ID allocation controller for the TileLink source-shrinker stage of an interconnect coupler. Maps wide upstream A-channel source IDs onto a small pool of downstream IDs, holds each mapping until the matching D-channel response completes, and restores the original ID on D. Only handshakes and source fields pass through this block; payload travels alongside in the coupler's buffer/width-widget datapath.

---
 rtl/tl_source_shrink_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_tl_source_shrink_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_source_shrink_ctrl.sv
// tl_source_shrink_ctrl
// Source-ID allocation controller for a TileLink source shrinker. Wide upstream
// A-channel source IDs are mapped onto a small pool of downstream IDs. Each
// mapping is held until the matching D-channel last beat, and the original ID
// is restored on D. Only handshakes and source fields pass through this block.
//
// Optional feature: define TL_SRCSHRINK_STATS_EN to add the stall_cnt output.
// It is a saturating count of cycles in which a first-beat A request waits
// because no downstream ID is free.
module tl_source_shrink_ctrl #(
    parameter int IN_W    = 8,
    parameter int OUT_IDS = 4,
    parameter int OUT_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_in_valid,
    output logic              a_in_ready,
    input  logic [IN_W-1:0]   a_in_source,
    input  logic              a_in_last,
    output logic              a_out_valid,
    input  logic              a_out_ready,
    output logic [OUT_W-1:0]  a_out_source,
    input  logic              d_in_valid,
    output logic              d_in_ready,
    input  logic [OUT_W-1:0]  d_in_source,
    input  logic              d_in_last,
    output logic              d_out_valid,
    input  logic              d_out_ready,
    output logic [IN_W-1:0]   d_out_source,
    output logic [4:0]        inflight,
    output logic              map_err
`ifdef TL_SRCSHRINK_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic [OUT_IDS-1:0] free_q, free_d;
    logic [IN_W-1:0]    map_q [OUT_IDS];
    logic [IN_W-1:0]    map_d [OUT_IDS];
    logic               burst_q, burst_d;
    logic [OUT_W-1:0]   held_q, held_d;
    logic [4:0]         inflight_q, inflight_d;
    logic               map_err_q, map_err_d;

    logic               any_free;
    logic [OUT_W-1:0]   sel;
    logic               d_hit;
    logic               d_id_free;
    logic [IN_W-1:0]    d_map_src;
    logic               a_fire;
    logic               d_fire;
    logic               alloc;
    logic               release_id;

    // Pick the lowest-index free ID from the registered bitmap, so an ID
    // released this cycle only becomes selectable on the next cycle.
    always_comb begin
        any_free = |free_q;
        sel      = '0;
        for (int i = OUT_IDS - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                sel = OUT_W'(i);
            end
        end
    end

    // Look up the D-channel ID; an ID outside the pool never matches and is
    // treated like an unallocated one.
    always_comb begin
        d_hit     = 1'b0;
        d_id_free = 1'b0;
        d_map_src = '0;
        for (int i = 0; i < OUT_IDS; i++) begin
            if (d_in_source == OUT_W'(i)) begin
                d_hit     = 1'b1;
                d_id_free = free_q[i];
                d_map_src = map_q[i];
            end
        end
    end

    // Handshakes: first beats need a free ID and bursts reuse the held ID.
    // Valids never depend on the opposite-direction ready.
    always_comb begin
        if (burst_q) begin
            a_out_valid  = a_in_valid;
            a_in_ready   = a_out_ready;
            a_out_source = held_q;
        end else begin
            a_out_valid  = a_in_valid & any_free;
            a_in_ready   = a_out_ready & any_free;
            a_out_source = sel;
        end
        d_out_valid  = d_in_valid;
        d_in_ready   = d_out_ready;
        d_out_source = d_map_src;
        inflight     = inflight_q;
        map_err      = map_err_q;
    end

    // Next-state computation for allocation, release, burst tracking and errors.
    always_comb begin
        a_fire     = a_in_valid & a_in_ready;
        d_fire     = d_in_valid & d_out_ready;
        alloc      = a_fire & ~burst_q;
        release_id = d_fire & d_in_last & d_hit & ~d_id_free;

        free_d     = free_q;
        map_d      = map_q;
        burst_d    = burst_q;
        held_d     = held_q;
        map_err_d  = map_err_q;

        if (alloc) begin
            free_d[sel] = 1'b0;
            map_d[sel]  = a_in_source;
            if (!a_in_last) begin
                burst_d = 1'b1;
                held_d  = sel;
            end
        end else if (a_fire && a_in_last) begin
            burst_d = 1'b0;
        end

        if (d_fire && (!d_hit || d_id_free)) begin
            map_err_d = 1'b1;
        end
        if (release_id) begin
            free_d[d_in_source] = 1'b1;
        end

        inflight_d = inflight_q + 5'(alloc) - 5'(release_id);
    end

    // State registers; reset discards every mapping at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            free_q     <= '1;
            for (int i = 0; i < OUT_IDS; i++) begin
                map_q[i] <= '0;
            end
            burst_q    <= 1'b0;
            held_q     <= '0;
            inflight_q <= '0;
            map_err_q  <= 1'b0;
        end else begin
            free_q     <= free_d;
            map_q      <= map_d;
            burst_q    <= burst_d;
            held_q     <= held_d;
            inflight_q <= inflight_d;
            map_err_q  <= map_err_d;
        end
    end

`ifdef TL_SRCSHRINK_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count first-beat stall cycles caused by an exhausted pool, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (a_in_valid && !burst_q && !any_free && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        stall_cnt = stall_cnt_q;
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_tl_source_shrink_ctrl.sv
// Directed self-checking bench for tl_source_shrink_ctrl.
module tb_tl_source_shrink_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_source = '0;
    logic       a_in_last = 1'b0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [1:0] a_out_source;
    logic       d_in_valid = 1'b0;
    logic       d_in_ready;
    logic [1:0] d_in_source = '0;
    logic       d_in_last = 1'b0;
    logic       d_out_valid;
    logic       d_out_ready = 1'b0;
    logic [7:0] d_out_source;
    logic [4:0] inflight;
    logic       map_err;
`ifdef TL_SRCSHRINK_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] aq[$];
    logic [31:0] dq[$];

    tl_source_shrink_ctrl #(.IN_W(8), .OUT_IDS(4), .OUT_W(2)) dut (
        .clock(clock), .reset(reset),
        .a_in_valid(a_in_valid), .a_in_ready(a_in_ready),
        .a_in_source(a_in_source), .a_in_last(a_in_last),
        .a_out_valid(a_out_valid), .a_out_ready(a_out_ready),
        .a_out_source(a_out_source),
        .d_in_valid(d_in_valid), .d_in_ready(d_in_ready),
        .d_in_source(d_in_source), .d_in_last(d_in_last),
        .d_out_valid(d_out_valid), .d_out_ready(d_out_ready),
        .d_out_source(d_out_source),
        .inflight(inflight), .map_err(map_err)
`ifdef TL_SRCSHRINK_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One A beat: expected downstream ID queued, compared when the beat fires.
    task automatic a_beat(input logic [7:0] src, input logic last, input logic [1:0] exp_id,
                          input string tag);
        int n;
        aq.push_back(32'(exp_id));
        a_in_valid  = 1'b1;
        a_in_source = src;
        a_in_last   = last;
        #1;
        n = 0;
        while (!a_in_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(a_in_ready & a_out_valid), 32'd1);
        check({tag, "_id"}, 32'(a_out_source), aq.pop_front());
        step();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    // One D beat: expected restored source queued, compared when the beat fires.
    task automatic d_beat(input logic [1:0] id, input logic last, input logic [7:0] exp_src,
                          input string tag);
        dq.push_back(32'(exp_src));
        d_in_valid  = 1'b1;
        d_in_source = id;
        d_in_last   = last;
        #1;
        check({tag, "_valid"}, 32'(d_out_valid & d_in_ready), 32'd1);
        check({tag, "_src"}, 32'(d_out_source), dq.pop_front());
        step();
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_map_err", 32'(map_err), 32'd0);
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_d_out_source", 32'(d_out_source), 32'd0);
        reset = 1'b1;
        a_out_ready = 1'b1;
        d_out_ready = 1'b1;
        step();
        check("rst_a_in_ready", 32'(a_in_ready), 32'd1);

        // Single beat round trip
        a_beat(8'h5A, 1'b1, 2'd0, "single_a");
        check("single_inflight1", 32'(inflight), 32'd1);
        d_beat(2'd0, 1'b1, 8'h5A, "single_d");
        check("single_inflight0", 32'(inflight), 32'd0);

        // Fill the pool
        a_beat(8'h10, 1'b1, 2'd0, "fill0");
        a_beat(8'h11, 1'b1, 2'd1, "fill1");
        a_beat(8'h12, 1'b1, 2'd2, "fill2");
        a_beat(8'h13, 1'b1, 2'd3, "fill3");
        check("fill_inflight4", 32'(inflight), 32'd4);
        a_in_valid = 1'b1; a_in_source = 8'h14; a_in_last = 1'b1;
        #1;
        check("full_a_in_ready", 32'(a_in_ready), 32'd0);
        check("full_a_out_valid", 32'(a_out_valid), 32'd0);
        step(); step();
        check("full_still_stalled", 32'(a_in_ready), 32'd0);
        d_in_valid = 1'b1; d_in_source = 2'd2; d_in_last = 1'b1;
        #1;
        check("free2_src", 32'(d_out_source), 32'h12);
        check("free2_same_cycle_stall", 32'(a_in_ready), 32'd0);
        step();
        d_in_valid = 1'b0;
        #1;
        check("realloc_ready", 32'(a_in_ready), 32'd1);
        check("realloc_id2", 32'(a_out_source), 32'd2);
        check("realloc_inflight3", 32'(inflight), 32'd3);
        step();
        a_in_valid = 1'b0;
        check("realloc_inflight4", 32'(inflight), 32'd4);

        // Simultaneous free of ID 1 and first-beat A
        a_in_valid = 1'b1; a_in_source = 8'h15; a_in_last = 1'b1;
        d_in_valid = 1'b1; d_in_source = 2'd1; d_in_last = 1'b1;
        #1;
        check("simul_src", 32'(d_out_source), 32'h11);
        check("simul_stall", 32'(a_in_ready), 32'd0);
        step();
        d_in_valid = 1'b0;
        #1;
        check("simul_id1", 32'(a_out_source), 32'd1);
        check("simul_ready", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        check("simul_inflight4", 32'(inflight), 32'd4);

        // Drain
        d_beat(2'd0, 1'b1, 8'h10, "drain0");
        d_beat(2'd1, 1'b1, 8'h15, "drain1");
        d_beat(2'd2, 1'b1, 8'h14, "drain2");
        d_beat(2'd3, 1'b1, 8'h13, "drain3");
        check("drain_inflight0", 32'(inflight), 32'd0);

        // Burst: ID 0 occupied, burst takes ID 1, ID 0 freed mid-burst
        a_beat(8'h30, 1'b1, 2'd0, "pre_burst");
        a_beat(8'h77, 1'b0, 2'd1, "burst_b0");
        a_beat(8'h77, 1'b0, 2'd1, "burst_b1");
        d_beat(2'd0, 1'b1, 8'h30, "burst_free0");
        a_beat(8'h77, 1'b0, 2'd1, "burst_b2");
        a_beat(8'h77, 1'b1, 2'd1, "burst_b3");
        check("burst_inflight1", 32'(inflight), 32'd1);
        a_beat(8'h40, 1'b1, 2'd0, "post_burst");
        d_beat(2'd1, 1'b0, 8'h77, "burst_d0");
        check("burst_d_nonlast_inflight", 32'(inflight), 32'd2);
        d_beat(2'd1, 1'b1, 8'h77, "burst_d1");
        d_beat(2'd0, 1'b1, 8'h40, "post_burst_d");
        check("burst_drain_inflight0", 32'(inflight), 32'd0);

        // Error on unallocated ID 3 (stale table entry forwarded)
        check("err_before", 32'(map_err), 32'd0);
        d_beat(2'd3, 1'b1, 8'h13, "err_d3");
        check("err_set", 32'(map_err), 32'd1);
        check("err_inflight", 32'(inflight), 32'd0);
        step();
        check("err_sticky", 32'(map_err), 32'd1);
        a_beat(8'h50, 1'b1, 2'd0, "err_a0");
        a_beat(8'h51, 1'b1, 2'd1, "err_a1");
        check("err_inflight2", 32'(inflight), 32'd2);

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b0;
        #1;
        check("arst_map_err", 32'(map_err), 32'd0);
        check("arst_inflight", 32'(inflight), 32'd0);
        check("arst_sel0", 32'(a_out_source), 32'd0);
        step();
        reset = 1'b1;
        a_in_valid = 1'b1; a_in_source = 8'h60; a_in_last = 1'b1; a_out_ready = 1'b0;
        #1;
        check("arst_all_free", 32'(a_out_valid), 32'd1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        d_beat(2'd0, 1'b1, 8'h00, "arst_old_d");
        check("arst_old_err", 32'(map_err), 32'd1);
        check("arst_old_inflight", 32'(inflight), 32'd0);

`ifdef TL_SRCSHRINK_STATS_EN
        // Stall counting with a full pool
        a_beat(8'h80, 1'b1, 2'd0, "st0");
        a_beat(8'h81, 1'b1, 2'd1, "st1");
        a_beat(8'h82, 1'b1, 2'd2, "st2");
        a_beat(8'h83, 1'b1, 2'd3, "st3");
        check("stats_zero", 32'(stall_cnt), 32'd0);
        a_in_valid = 1'b1; a_in_source = 8'h84; a_in_last = 1'b1;
        for (int i = 0; i < 20; i++) step();
        a_in_valid = 1'b0;
        check("stats_20", 32'(stall_cnt), 32'd20);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
